// File: rtl/axi_ad9364_pkg.sv
// Shared definitions for the AD9364 transmit test-pattern source:
// pattern mode encodings, PRBS-15 seed and step rule, and the run-state enum.
package axi_ad9364_pkg;

    typedef enum logic [1:0] {
        PG_MODE_ZERO = 2'd0,
        PG_MODE_ALT  = 2'd1,
        PG_MODE_RAMP = 2'd2,
        PG_MODE_PRBS = 2'd3
    } pg_mode_e;

    localparam logic [14:0] PRBS15_SEED = 15'h7FFF;

    typedef enum logic {
        PG_IDLE = 1'b0,
        PG_RUN  = 1'b1
    } pg_state_e;

    // One PRBS-15 step: shift left, feed back bit14 ^ bit13 into bit 0.
    function automatic logic [14:0] prbs15_next(input logic [14:0] s);
        return {s[13:0], s[14] ^ s[13]};
    endfunction

endpackage

// File: rtl/axi_ad9364_prbs15.sv
// PRBS-15 state register for the pattern source.
// Only built when AXI_AD9364_PATTERN_GEN_PRBS_EN is defined; otherwise the
// pattern source has no LFSR at all.
`ifdef AXI_AD9364_PATTERN_GEN_PRBS_EN
module axi_ad9364_prbs15
    import axi_ad9364_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        init,
    input  logic        step,
    output logic [14:0] state
);

    logic [14:0] lfsr_q;
    logic [14:0] lfsr_d;

    // Reload the seed on init; init together with step means the seed is
    // consumed this beat, so the register lands one step past it.
    always_comb begin
        lfsr_d = lfsr_q;
        if (init) begin
            lfsr_d = step ? prbs15_next(PRBS15_SEED) : PRBS15_SEED;
        end else if (step) begin
            lfsr_d = prbs15_next(lfsr_q);
        end
    end

    // LFSR state register, seeded on reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lfsr_q <= PRBS15_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign state = lfsr_q;

endmodule
`endif

// File: rtl/axi_ad9364_pattern_gen.sv
// Transmit-side test pattern source for the AD9364 DAC data path.
// Issues one beat every VALID_DIV cycles while enabled, carrying a zero,
// alternating, ramp or PRBS-15 pattern on one or two channels.
// Optional feature: define AXI_AD9364_PATTERN_GEN_PRBS_EN to build the PRBS-15
// pattern; without it mode 3 produces zeros with unchanged cadence.
module axi_ad9364_pattern_gen
    import axi_ad9364_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 12,
    parameter int unsigned NUM_CHANNELS = 1,
    parameter int unsigned VALID_DIV    = 2,
    parameter int unsigned PAT_I0       = 'o2064,
    parameter int unsigned PAT_I1       = 'o4402,
    parameter int unsigned PAT_Q0       = 'o1753,
    parameter int unsigned PAT_Q1       = 'o1337
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  enable,
    input  logic [1:0]            mode,
    output logic                  dac_valid,
    output logic [DATA_WIDTH-1:0] dac_data_i1,
    output logic [DATA_WIDTH-1:0] dac_data_q1,
    output logic [DATA_WIDTH-1:0] dac_data_i2,
    output logic [DATA_WIDTH-1:0] dac_data_q2,
    output logic                  dac_r1_mode,
    output logic [15:0]           beat_count,
    output logic                  running
);

    localparam logic [DATA_WIDTH-1:0] PAT_I0_W = DATA_WIDTH'(PAT_I0);
    localparam logic [DATA_WIDTH-1:0] PAT_I1_W = DATA_WIDTH'(PAT_I1);
    localparam logic [DATA_WIDTH-1:0] PAT_Q0_W = DATA_WIDTH'(PAT_Q0);
    localparam logic [DATA_WIDTH-1:0] PAT_Q1_W = DATA_WIDTH'(PAT_Q1);
    localparam logic [DATA_WIDTH-1:0] MSB_MASK = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0] RAMP_ONE = DATA_WIDTH'(1);
    localparam logic [3:0]            DIV_LAST = 4'(VALID_DIV - 1);
    localparam bit                    DUAL     = (NUM_CHANNELS == 2);

    pg_state_e             state_q, state_d;
    logic [1:0]            mode_q;
    logic [3:0]            div_cnt_q, div_cnt_d;
    logic                  phase_q, phase_d;
    logic [DATA_WIDTH-1:0] ramp_q, ramp_d;
    logic [15:0]           cnt_q, cnt_d;
    logic [15:0]           beat_count_q, beat_count_d;
    logic                  valid_q, valid_d;
    logic                  running_q, running_d;
    logic [DATA_WIDTH-1:0] i1_q, i1_d, q1_q, q1_d, i2_q, i2_d, q2_q, q2_d;

    logic                  start;
    logic                  active;
    logic                  restart;
    logic                  beat;
    logic [3:0]            cur_div;
    logic                  cur_phase;
    logic [DATA_WIDTH-1:0] cur_ramp;
    logic [15:0]           cur_cnt;
    logic [DATA_WIDTH-1:0] pat_i1, pat_q1;
    logic                  pat_zero;

    // A mode change while running restarts the sequence: the pattern state is
    // taken as freshly initialised for this cycle, which then issues beat 0.
    assign start     = (state_q == PG_IDLE) && enable;
    assign active    = (state_q == PG_RUN) && enable;
    assign restart   = active && (mode != mode_q);
    assign cur_div   = restart ? 4'd0 : div_cnt_q;
    assign cur_phase = restart ? 1'b0 : phase_q;
    assign cur_ramp  = restart ? '0 : ramp_q;
    assign cur_cnt   = restart ? 16'd0 : cnt_q;
    assign beat      = active && (cur_div == 4'd0);

`ifdef AXI_AD9364_PATTERN_GEN_PRBS_EN
    logic [14:0] lfsr_state;
    logic [14:0] cur_lfsr;

    axi_ad9364_prbs15 u_prbs15 (
        .clk   (clk),
        .rstn  (rstn),
        .init  (start || restart),
        .step  (beat),
        .state (lfsr_state)
    );

    assign cur_lfsr = restart ? PRBS15_SEED : lfsr_state;
`endif

    // Pattern words for the beat being issued, from the pre-advance state.
    // The zero flag also forces channel 2 to zero so zero mode is all-zero.
    always_comb begin
        pat_i1   = '0;
        pat_q1   = '0;
        pat_zero = 1'b1;
        case (pg_mode_e'(mode))
            PG_MODE_ALT: begin
                pat_zero = 1'b0;
                pat_i1   = cur_phase ? PAT_I1_W : PAT_I0_W;
                pat_q1   = cur_phase ? PAT_Q1_W : PAT_Q0_W;
            end
            PG_MODE_RAMP: begin
                pat_zero = 1'b0;
                pat_i1   = cur_ramp;
                pat_q1   = cur_ramp ^ MSB_MASK;
            end
`ifdef AXI_AD9364_PATTERN_GEN_PRBS_EN
            PG_MODE_PRBS: begin
                pat_zero = 1'b0;
                pat_i1   = cur_lfsr[DATA_WIDTH-1:0];
                pat_q1   = ~cur_lfsr[DATA_WIDTH-1:0];
            end
`endif
            default: begin
            end
        endcase
    end

    // Run-state next-state logic: enable alone decides IDLE versus RUN.
    always_comb begin
        state_d = state_q;
        case (state_q)
            PG_IDLE: if (enable)  state_d = PG_RUN;
            PG_RUN:  if (!enable) state_d = PG_IDLE;
            default: state_d = PG_IDLE;
        endcase
    end

    // Datapath next-state: initialise on entry, otherwise divide the cadence
    // and on each beat load the outputs and advance the pattern state.
    always_comb begin
        div_cnt_d    = div_cnt_q;
        phase_d      = phase_q;
        ramp_d       = ramp_q;
        cnt_d        = cnt_q;
        beat_count_d = beat_count_q;
        valid_d      = 1'b0;
        running_d    = active;
        i1_d         = i1_q;
        q1_d         = q1_q;
        i2_d         = i2_q;
        q2_d         = q2_q;
        if (start) begin
            div_cnt_d    = 4'd0;
            phase_d      = 1'b0;
            ramp_d       = '0;
            cnt_d        = 16'd0;
            beat_count_d = 16'd0;
        end else if (active) begin
            div_cnt_d = (cur_div == DIV_LAST) ? 4'd0 : cur_div + 4'd1;
            if (beat) begin
                valid_d      = 1'b1;
                i1_d         = pat_i1;
                q1_d         = pat_q1;
                i2_d         = (DUAL && !pat_zero) ? ~pat_i1 : '0;
                q2_d         = (DUAL && !pat_zero) ? ~pat_q1 : '0;
                phase_d      = ~cur_phase;
                ramp_d       = cur_ramp + RAMP_ONE;
                cnt_d        = cur_cnt + 16'd1;
                beat_count_d = cur_cnt;
            end
        end
    end

    // Run-state register and the mode seen last cycle for restart detection.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= PG_IDLE;
            mode_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode;
        end
    end

    // Pattern state and registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            div_cnt_q    <= 4'd0;
            phase_q      <= 1'b0;
            ramp_q       <= '0;
            cnt_q        <= 16'd0;
            beat_count_q <= 16'd0;
            valid_q      <= 1'b0;
            running_q    <= 1'b0;
            i1_q         <= '0;
            q1_q         <= '0;
            i2_q         <= '0;
            q2_q         <= '0;
        end else begin
            div_cnt_q    <= div_cnt_d;
            phase_q      <= phase_d;
            ramp_q       <= ramp_d;
            cnt_q        <= cnt_d;
            beat_count_q <= beat_count_d;
            valid_q      <= valid_d;
            running_q    <= running_d;
            i1_q         <= i1_d;
            q1_q         <= q1_d;
            i2_q         <= i2_d;
            q2_q         <= q2_d;
        end
    end

    assign dac_valid   = valid_q;
    assign dac_data_i1 = i1_q;
    assign dac_data_q1 = q1_q;
    assign dac_data_i2 = i2_q;
    assign dac_data_q2 = q2_q;
    assign dac_r1_mode = (NUM_CHANNELS == 1);
    assign beat_count  = beat_count_q;
    assign running     = running_q;

endmodule

// File: tb/tb_axi_ad9364_pattern_gen.sv
// Testbench for axi_ad9364_pattern_gen: two instances (1 channel / divide-by-2
// and 2 channels / continuous) driven by shared stimulus, checked against a
// beat-index reference model, a vector table and hand-written corner sequences.
`timescale 1ns/1ps
module tb_axi_ad9364_pattern_gen;

    localparam int DIV_A = 2;
    localparam int DIV_B = 1;

    logic        clk = 1'b0;
    logic        rstn;
    logic        enable;
    logic [1:0]  mode;

    logic        aValid, bValid, aR1, bR1, aRun, bRun;
    logic [11:0] aI1, aQ1, aI2, aQ2, bI1, bQ1, bI2, bQ2;
    logic [15:0] aBc, bBc;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state, index 0 = instance A, 1 = instance B
    bit          mRun[2];
    int          mT[2];
    logic [1:0]  mLast[2];
    logic [14:0] mPrbs[2];
    int          mPrbsK[2];
    logic        eValid[2];
    logic        eRun[2];
    logic [11:0] eI1[2], eQ1[2], eI2[2], eQ2[2];
    logic [15:0] eBc[2];

    typedef struct {
        bit          en;
        logic [1:0]  md;
        logic        expValid;
        logic [11:0] expI1;
        logic [11:0] expQ1;
        logic [15:0] expBc;
        logic        expRun;
    } vec_t;

    vec_t tbl[11];

`ifdef AXI_AD9364_PATTERN_GEN_PRBS_EN
    localparam logic [11:0] B0I1 = 12'hFFF, B0Q1 = 12'h000, B0I2 = 12'h000, B0Q2 = 12'hFFF;
    localparam logic [11:0] B1I1 = 12'hFFE, B1Q1 = 12'h001;
`else
    localparam logic [11:0] B0I1 = 12'h000, B0Q1 = 12'h000, B0I2 = 12'h000, B0Q2 = 12'h000;
    localparam logic [11:0] B1I1 = 12'h000, B1Q1 = 12'h000;
`endif

    always #5 clk = ~clk;

    axi_ad9364_pattern_gen #(
        .DATA_WIDTH(12), .NUM_CHANNELS(1), .VALID_DIV(DIV_A)
    ) dutA (
        .clk(clk), .rstn(rstn), .enable(enable), .mode(mode),
        .dac_valid(aValid), .dac_data_i1(aI1), .dac_data_q1(aQ1),
        .dac_data_i2(aI2), .dac_data_q2(aQ2), .dac_r1_mode(aR1),
        .beat_count(aBc), .running(aRun)
    );

    axi_ad9364_pattern_gen #(
        .DATA_WIDTH(12), .NUM_CHANNELS(2), .VALID_DIV(DIV_B)
    ) dutB (
        .clk(clk), .rstn(rstn), .enable(enable), .mode(mode),
        .dac_valid(bValid), .dac_data_i1(bI1), .dac_data_q1(bQ1),
        .dac_data_i2(bI2), .dac_data_q2(bQ2), .dac_r1_mode(bR1),
        .beat_count(bBc), .running(bRun)
    );

    function automatic int divOf(input int d);
        return (d == 0) ? DIV_A : DIV_B;
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    task automatic modelReset();
        for (int d = 0; d < 2; d++) begin
            mRun[d] = 0; mT[d] = 0; mLast[d] = 2'd0;
            mPrbs[d] = 15'h7FFF; mPrbsK[d] = 0;
            eValid[d] = 0; eRun[d] = 0; eBc[d] = 16'd0;
            eI1[d] = 12'h0; eQ1[d] = 12'h0; eI2[d] = 12'h0; eQ2[d] = 12'h0;
        end
    endtask

    // Behaviour at one rising edge, from time since start and beat index
    task automatic modelEdge(input int d);
        int k;
        logic [11:0] i1, q1;
        bit zero;
        if (!mRun[d]) begin
            eValid[d] = 0; eRun[d] = 0;
            if (enable) begin mRun[d] = 1; mT[d] = 0; eBc[d] = 16'd0; end
        end else if (!enable) begin
            mRun[d] = 0; eValid[d] = 0; eRun[d] = 0;
        end else begin
            eRun[d] = 1;
            if (mode != mLast[d]) mT[d] = 0;
            if (mT[d] % divOf(d) == 0) begin
                k = mT[d] / divOf(d);
                if (k == 0) begin mPrbs[d] = 15'h7FFF; mPrbsK[d] = 0; end
                while (mPrbsK[d] < k) begin
                    mPrbs[d] = {mPrbs[d][13:0], mPrbs[d][14] ^ mPrbs[d][13]};
                    mPrbsK[d]++;
                end
                zero = 1; i1 = 12'h0; q1 = 12'h0;
                case (mode)
                    2'd1: begin
                        zero = 0;
                        i1 = (k % 2 == 0) ? 12'o2064 : 12'o4402;
                        q1 = (k % 2 == 0) ? 12'o1753 : 12'o1337;
                    end
                    2'd2: begin zero = 0; i1 = 12'(k % 4096); q1 = i1 ^ 12'h800; end
`ifdef AXI_AD9364_PATTERN_GEN_PRBS_EN
                    2'd3: begin zero = 0; i1 = mPrbs[d][11:0]; q1 = ~i1; end
`endif
                    default: begin end
                endcase
                eValid[d] = 1; eI1[d] = i1; eQ1[d] = q1;
                eI2[d] = (d == 1 && !zero) ? ~i1 : 12'h0;
                eQ2[d] = (d == 1 && !zero) ? ~q1 : 12'h0;
                eBc[d] = 16'(k);
            end else begin
                eValid[d] = 0;
            end
            mT[d]++;
        end
        mLast[d] = mode;
    endtask

    task automatic checkDut(input int d, input logic v, input logic [11:0] i1, input logic [11:0] q1,
                            input logic [11:0] i2, input logic [11:0] q2, input logic r1,
                            input logic [15:0] bc, input logic run);
        string p;
        p = (d == 0) ? "A" : "B";
        cmp({p, ".valid"}, v, eValid[d]);
        cmp({p, ".i1"}, i1, eI1[d]);
        cmp({p, ".q1"}, q1, eQ1[d]);
        cmp({p, ".i2"}, i2, eI2[d]);
        cmp({p, ".q2"}, q2, eQ2[d]);
        cmp({p, ".r1_mode"}, r1, (d == 0));
        cmp({p, ".beat_count"}, bc, eBc[d]);
        cmp({p, ".running"}, run, eRun[d]);
    endtask

    task automatic checkOutput();
        checkDut(0, aValid, aI1, aQ1, aI2, aQ2, aR1, aBc, aRun);
        checkDut(1, bValid, bI1, bQ1, bI2, bQ2, bR1, bBc, bRun);
    endtask

    task automatic applyStimulus(input bit en, input logic [1:0] md);
        enable = en;
        mode = md;
        @(posedge clk);
        modelEdge(0);
        modelEdge(1);
        #1;
        checkOutput();
    endtask

    initial begin
        bit en;
        logic [1:0] md;

        // Alternating mode on instance A: expected words written out by hand
        tbl[0]  = '{1'b1, 2'd1, 1'b0, 12'o0000, 12'o0000, 16'd0, 1'b0};
        tbl[1]  = '{1'b1, 2'd1, 1'b1, 12'o2064, 12'o1753, 16'd0, 1'b1};
        tbl[2]  = '{1'b1, 2'd1, 1'b0, 12'o2064, 12'o1753, 16'd0, 1'b1};
        tbl[3]  = '{1'b1, 2'd1, 1'b1, 12'o4402, 12'o1337, 16'd1, 1'b1};
        tbl[4]  = '{1'b1, 2'd1, 1'b0, 12'o4402, 12'o1337, 16'd1, 1'b1};
        tbl[5]  = '{1'b1, 2'd1, 1'b1, 12'o2064, 12'o1753, 16'd2, 1'b1};
        tbl[6]  = '{1'b0, 2'd1, 1'b0, 12'o2064, 12'o1753, 16'd2, 1'b0};
        tbl[7]  = '{1'b0, 2'd1, 1'b0, 12'o2064, 12'o1753, 16'd2, 1'b0};
        tbl[8]  = '{1'b1, 2'd1, 1'b0, 12'o2064, 12'o1753, 16'd0, 1'b0};
        tbl[9]  = '{1'b1, 2'd1, 1'b1, 12'o2064, 12'o1753, 16'd0, 1'b1};
        tbl[10] = '{1'b0, 2'd1, 1'b0, 12'o2064, 12'o1753, 16'd0, 1'b0};

        rstn = 1'b0;
        enable = 1'b0;
        mode = 2'd0;
        modelReset();
        #12;
        $display("[TB] reset values");
        checkOutput();
        #1 rstn = 1'b1;

        $display("[TB] vector table, alternating pattern");
        for (int i = 0; i < 11; i++) begin
            applyStimulus(tbl[i].en, tbl[i].md);
            cmp($sformatf("tbl[%0d].valid", i), aValid, tbl[i].expValid);
            cmp($sformatf("tbl[%0d].i1", i), aI1, tbl[i].expI1);
            cmp($sformatf("tbl[%0d].q1", i), aQ1, tbl[i].expQ1);
            cmp($sformatf("tbl[%0d].i2", i), aI2, 12'h000);
            cmp($sformatf("tbl[%0d].beat_count", i), aBc, tbl[i].expBc);
            cmp($sformatf("tbl[%0d].running", i), aRun, tbl[i].expRun);
        end

        $display("[TB] PRBS first beats");
        applyStimulus(1'b1, 2'd3);
        applyStimulus(1'b1, 2'd3);
        cmp("prbs.b0.valid", bValid, 1'b1);
        cmp("prbs.b0.i1", bI1, B0I1);
        cmp("prbs.b0.q1", bQ1, B0Q1);
        cmp("prbs.b0.i2", bI2, B0I2);
        cmp("prbs.b0.q2", bQ2, B0Q2);
        cmp("prbs.a0.valid", aValid, 1'b1);
        cmp("prbs.a0.i1", aI1, B0I1);
        cmp("prbs.a0.q2", aQ2, 12'h000);
        applyStimulus(1'b1, 2'd3);
        cmp("prbs.b1.i1", bI1, B1I1);
        cmp("prbs.b1.q1", bQ1, B1Q1);
        cmp("prbs.a1.valid", aValid, 1'b0);
        applyStimulus(1'b0, 2'd3);

        $display("[TB] mode switch ramp to alternating at beat 5");
        applyStimulus(1'b1, 2'd2);
        for (int j = 0; j < 11; j++) applyStimulus(1'b1, 2'd2);
        cmp("sw.beat5.valid", aValid, 1'b1);
        cmp("sw.beat5.beat_count", aBc, 16'd5);
        cmp("sw.beat5.i1", aI1, 12'h005);
        applyStimulus(1'b1, 2'd1);
        cmp("sw.restart.valid", aValid, 1'b1);
        cmp("sw.restart.i1", aI1, 12'o2064);
        cmp("sw.restart.q1", aQ1, 12'o1753);
        cmp("sw.restart.beat_count", aBc, 16'd0);
        applyStimulus(1'b1, 2'd1);
        cmp("sw.gap.valid", aValid, 1'b0);
        applyStimulus(1'b1, 2'd1);
        cmp("sw.next.i1", aI1, 12'o4402);
        cmp("sw.next.beat_count", aBc, 16'd1);
        applyStimulus(1'b0, 2'd1);

        $display("[TB] ramp wrap on continuous instance");
        applyStimulus(1'b1, 2'd2);
        for (int j = 1; j <= 4097; j++) begin
            applyStimulus(1'b1, 2'd2);
            if (j == 4096) begin
                cmp("wrap.4095.i1", bI1, 12'hFFF);
                cmp("wrap.4095.q1", bQ1, 12'h7FF);
            end
            if (j == 4097) begin
                cmp("wrap.4096.i1", bI1, 12'h000);
                cmp("wrap.4096.q1", bQ1, 12'h800);
                cmp("wrap.4096.beat_count", bBc, 16'd4096);
            end
        end
        applyStimulus(1'b0, 2'd2);

        $display("[TB] asynchronous reset mid-run");
        for (int j = 0; j < 7; j++) applyStimulus(1'b1, 2'd2);
        rstn = 1'b0;
        #1;
        modelReset();
        checkOutput();
        cmp("rst.a.valid", aValid, 1'b0);
        cmp("rst.b.q1", bQ1, 12'h000);
        cmp("rst.b.running", bRun, 1'b0);
        #1 rstn = 1'b1;
        applyStimulus(1'b1, 2'd2);
        cmp("rst.entry.valid", bValid, 1'b0);
        applyStimulus(1'b1, 2'd2);
        cmp("rst.beat0.q1", bQ1, 12'h800);
        cmp("rst.beat0.beat_count", bBc, 16'd0);
        cmp("rst.beat0.running", bRun, 1'b1);

        $display("[TB] randomized run");
        en = 1'b1;
        md = 2'd2;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) en = !en;
            if ($urandom_range(0, 15) == 0) md = 2'($urandom_range(0, 3));
            applyStimulus(en, md);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
